// File: rtl/prog_mem_loader.sv
`default_nettype none
// ============================================================================
// Module  : prog_mem_loader
// Brief   : Loads a length-prefixed 16-bit program from a byte stream into
//           instruction memory, then serves registered instruction fetches.
// Revision: 1.0 - initial release
// ============================================================================
module prog_mem_loader #(
  parameter int DEPTH = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [10:0] program_counter,
  output logic [15:0] instruction,
  output logic        cpu_run,
  output logic [11:0] word_count,
  output logic        load_error
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [12:0] DEPTH_W = 13'(DEPTH);

  typedef enum logic [2:0] {
    HDR_LO  = 3'd0,
    HDR_HI  = 3'd1,
    DATA_LO = 3'd2,
    DATA_HI = 3'd3,
    RUN     = 3'd4,
    ERR     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] count_q, count_d;
  logic [11:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]  lo_byte_q, lo_byte_d;
  logic [15:0] instr_q, instr_d;

  logic [15:0] mem [DEPTH];

  logic        loading;
  logic        xfer;
  logic        mem_we;
  logic [11:0] hdr_count;
  logic [11:0] wr_ptr_inc;
  logic [11:0] pc_ext;

  assign loading    = (state_q == HDR_LO) || (state_q == HDR_HI) ||
                      (state_q == DATA_LO) || (state_q == DATA_HI);
  // Gating with rst keeps a byte offered during reset from being consumed.
  assign rx_ready   = loading && !rst;
  assign xfer       = rx_valid && rx_ready;
  assign mem_we     = xfer && (state_q == DATA_HI);
  assign hdr_count  = {rx_data[3:0], count_q[7:0]};
  assign wr_ptr_inc = wr_ptr_q + 12'd1;
  assign pc_ext     = {1'b0, program_counter};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    lo_byte_d = lo_byte_q;
    case (state_q)
      HDR_LO: begin
        if (xfer) begin
          count_d = {count_q[11:8], rx_data};
          state_d = HDR_HI;
        end
      end
      HDR_HI: begin
        if (xfer) begin
          count_d = hdr_count;
          if ((hdr_count == 12'd0) || ({1'b0, hdr_count} > DEPTH_W) ||
              (rx_data[7:4] != 4'h0)) begin
            state_d = ERR;
          end else begin
            state_d = DATA_LO;
          end
        end
      end
      DATA_LO: begin
        if (xfer) begin
          lo_byte_d = rx_data;
          state_d   = DATA_HI;
        end
      end
      DATA_HI: begin
        if (xfer) begin
          wr_ptr_d = wr_ptr_inc;
          state_d  = (wr_ptr_inc == count_q) ? RUN : DATA_LO;
        end
      end
      RUN:     state_d = RUN;
      ERR:     state_d = ERR;
      default: state_d = HDR_LO;
    endcase
  end

  // Reads beyond the loaded program return zero, so stale memory stays hidden.
  always_comb begin
    instr_d = 16'h0000;
    if ((state_q == RUN) && (pc_ext < count_q)) begin
      instr_d = mem[pc_ext[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HDR_LO;
      count_q   <= 12'd0;
      wr_ptr_q  <= 12'd0;
      lo_byte_q <= 8'd0;
      instr_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      lo_byte_q <= lo_byte_d;
      instr_q   <= instr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q[AW-1:0]] <= {rx_data, lo_byte_q};
    end
  end

  assign instruction = instr_q;
  assign cpu_run     = (state_q == RUN);
  assign load_error  = (state_q == ERR);
  assign word_count  = (state_q == RUN) ? count_q : 12'd0;

endmodule
`default_nettype wire
